// File: rtl/multi_bank_memory_unit_if.sv
// Writer/reader bus of the banked song memory: the recorder appends and clears,
// the player requests words; clk and rst_n stay plain ports on the unit.
interface multi_bank_memory_unit_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int NUM_BANKS   = 4,
  parameter int STATE_WIDTH = 2
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic [STATE_WIDTH-1:0] current_state;
  logic                   write_en;
  logic [BANK_W-1:0]      wr_bank;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   clear_en;
  logic                   read_en;
  logic [BANK_W-1:0]      rd_bank;
  logic                   read_rst;
  logic                   loop_en;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   output_ready;
  logic                   end_of_data;
  logic                   full;
  logic [LEN_W-1:0]       duration;

  modport master (
    output current_state, write_en, wr_bank, data_in, clear_en,
    output read_en, rd_bank, read_rst, loop_en,
    input  data_out, output_ready, end_of_data, full, duration
  );

  modport slave (
    input  current_state, write_en, wr_bank, data_in, clear_en,
    input  read_en, rd_bank, read_rst, loop_en,
    output data_out, output_ready, end_of_data, full, duration
  );
endinterface

// File: rtl/multi_bank_memory_unit.sv
// Banked append-only song memory: NUM_BANKS independent banks with their own
// length counters, one playback pointer with restart, end-of-data and looping.
module multi_bank_memory_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int NUM_BANKS   = 4,
  parameter int STATE_WIDTH = 2
) (
  input logic clk,
  input logic rst_n,
  multi_bank_memory_unit_if.slave bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [STATE_WIDTH-1:0] ST_AUTOPLAY = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] ST_LEARNING = STATE_WIDTH'(1);
  localparam logic [LEN_W-1:0]       LEN_FULL    = LEN_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [LEN_W-1:0]      len_q [NUM_BANKS];
  logic [LEN_W-1:0]      len_d [NUM_BANKS];
  logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [BANK_W-1:0]     rd_bank_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  output_ready_q, output_ready_d;
  logic                  end_of_data_q, end_of_data_d;

  logic                  wr_ok_s, rd_ok_s, mem_we_s, mode_ok_s, restart_s;
  logic [LEN_W-1:0]      wr_len_s, rd_len_s;
  logic [DATA_WIDTH-1:0] rd_word_s, first_word_s;

  // Bank indices beyond NUM_BANKS behave as permanently empty banks
  assign wr_ok_s   = (32'(bus.wr_bank) < NUM_BANKS);
  assign rd_ok_s   = (32'(bus.rd_bank) < NUM_BANKS);
  assign wr_len_s  = wr_ok_s ? len_q[bus.wr_bank] : LEN_W'(0);
  assign rd_len_s  = rd_ok_s ? len_q[bus.rd_bank] : LEN_W'(0);
  assign mode_ok_s = (bus.current_state == ST_AUTOPLAY) || (bus.current_state == ST_LEARNING);
  assign restart_s = bus.read_rst || !mode_ok_s || (bus.rd_bank != rd_bank_q);
  assign rd_word_s    = mem_q[bus.rd_bank][rd_ptr_q[ADDR_W-1:0]];
  assign first_word_s = mem_q[bus.rd_bank][ADDR_W'(0)];

  assign bus.full         = wr_ok_s && (wr_len_s == LEN_FULL);
  assign bus.duration     = rd_len_s;
  assign bus.data_out     = data_out_q;
  assign bus.output_ready = output_ready_q;
  assign bus.end_of_data  = end_of_data_q;

  // Append/clear: clear wins over a same-cycle write, writes to a full bank drop
  always_comb begin
    len_d    = len_q;
    mem_we_s = 1'b0;
    if (wr_ok_s && bus.clear_en) begin
      len_d[bus.wr_bank] = LEN_W'(0);
    end else if (wr_ok_s && bus.write_en && (wr_len_s < LEN_FULL)) begin
      mem_we_s           = 1'b1;
      len_d[bus.wr_bank] = wr_len_s + LEN_W'(1);
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Playback: restart beats read_en; reads use the pre-edge bank length
  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    data_out_d     = data_out_q;
    output_ready_d = 1'b0;
    end_of_data_d  = end_of_data_q;
    if (restart_s) begin
      rd_ptr_d      = LEN_W'(0);
      data_out_d    = DATA_WIDTH'(0);
      end_of_data_d = 1'b0;
    end else if (bus.read_en) begin
      if (rd_ptr_q < rd_len_s) begin
        data_out_d     = rd_word_s;
        rd_ptr_d       = rd_ptr_q + LEN_W'(1);
        output_ready_d = 1'b1;
      end else if ((bus.current_state == ST_AUTOPLAY) && bus.loop_en &&
                   (rd_len_s != LEN_W'(0))) begin
        data_out_d     = first_word_s;
        rd_ptr_d       = LEN_W'(1);
        output_ready_d = 1'b1;
      end else begin
        end_of_data_d = 1'b1;
      end
    end else begin
      output_ready_d = 1'b0;
    end
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[bus.wr_bank][wr_len_s[ADDR_W-1:0]] <= bus.data_in;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        len_q[b] <= LEN_W'(0);
      end
      rd_ptr_q       <= LEN_W'(0);
      rd_bank_q      <= BANK_W'(0);
      data_out_q     <= DATA_WIDTH'(0);
      output_ready_q <= 1'b0;
      end_of_data_q  <= 1'b0;
    end else begin
      len_q          <= len_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_bank_q      <= bus.rd_bank;
      data_out_q     <= data_out_d;
      output_ready_q <= output_ready_d;
      end_of_data_q  <= end_of_data_d;
    end
  end
endmodule
